// File: rtl/programcounter_stack.sv
// Fetch-stage program counter with a DEPTH-entry return stack; every command lands one edge after its strobe.
// No backpressure: commands are accepted every cycle, and a call on a full stack or a ret on an empty stack is dropped and flagged.
module programcounter_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inc,
  input  logic                       jmp,
  input  logic                       call,
  input  logic                       ret,
  input  logic [AW-1:0]              addr_in,
  input  logic                       err_clr,
  output logic [AW-1:0]              adout,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stack_empty,
  output logic                       stack_full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(DEPTH);

  logic [AW-1:0]  stack [DEPTH];
  logic [AW-1:0]  adout_nxt;
  logic [SPW-1:0] sp_nxt;
  logic [SPW-1:0] sp_dec;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  pop_idx;
  logic           push;
  logic           ovf_set;
  logic           unf_set;

  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SPW'(DEPTH));
  assign sp_dec      = sp - SPW'(1);
  assign push_idx    = sp[IW-1:0];
  assign pop_idx     = sp_dec[IW-1:0];

  // Priority chain: inc > jmp > call > ret > hold.
  always_comb begin
    adout_nxt = adout;
    sp_nxt    = sp;
    push      = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (inc) begin
      adout_nxt = adout + AW'(1);
    end else if (jmp) begin
      adout_nxt = addr_in + AW'(1);
    end else if (call) begin
      if (stack_full) begin
        ovf_set = 1'b1;
      end else begin
        push      = 1'b1;
        sp_nxt    = sp + SPW'(1);
        adout_nxt = addr_in + AW'(1);
      end
    end else if (ret) begin
      if (stack_empty) begin
        unf_set = 1'b1;
      end else begin
        sp_nxt    = sp_dec;
        adout_nxt = stack[pop_idx] + AW'(2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adout <= '0;
      sp    <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      adout <= adout_nxt;
      sp    <= sp_nxt;
      if (push) stack[push_idx] <= adout;
      // A new fault in the clearing cycle keeps its flag set.
      ovf <= ovf_set | (ovf & ~err_clr);
      unf <= unf_set | (unf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_programcounter_stack.sv
// Self-checking bench for programcounter_stack: directed scenarios plus randomized commands against a queue-based model.
module tb_programcounter_stack;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inc = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0, err_clr = 1'b0;
  logic [7:0] addr_in = 8'h00;
  logic [7:0] adout;
  logic [2:0] sp;
  logic       stack_empty, stack_full, ovf, unf;

  int checks   = 0;
  int failures = 0;

  bit [7:0] m_adout;
  bit [7:0] m_stk[$];
  bit       m_ovf, m_unf;

  programcounter_stack #(.AW(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .inc(inc), .jmp(jmp), .call(call), .ret(ret),
    .addr_in(addr_in), .err_clr(err_clr), .adout(adout), .sp(sp),
    .stack_empty(stack_empty), .stack_full(stack_full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_adout = 8'h00;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input bit i, input bit j, input bit c, input bit r,
                            input bit [7:0] a, input bit clr);
    bit o = 1'b0;
    bit u = 1'b0;
    if (i) m_adout = m_adout + 8'd1;
    else if (j) m_adout = a + 8'd1;
    else if (c) begin
      if (m_stk.size() == 4) o = 1'b1;
      else begin
        m_stk.push_back(m_adout);
        m_adout = a + 8'd1;
      end
    end else if (r) begin
      if (m_stk.size() == 0) u = 1'b1;
      else m_adout = m_stk.pop_back() + 8'd2;
    end
    m_ovf = o | (m_ovf & !clr);
    m_unf = u | (m_unf & !clr);
  endtask

  // Drive one command at the falling edge, let it land on the rising edge, return at the next falling edge.
  task automatic cyc(input bit i, input bit j, input bit c, input bit r,
                     input bit [7:0] a, input bit clr);
    inc = i; jmp = j; call = c; ret = r; addr_in = a; err_clr = clr;
    @(posedge clk);
    model_step(i, j, c, r, a, clr);
    @(negedge clk);
    inc = 0; jmp = 0; call = 0; ret = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #12;
    checks++; if (adout !== 8'h00) begin failures++; $display("FAIL reset_adout got=%h exp=00", adout); end
    checks++; if (sp !== 3'd0) begin failures++; $display("FAIL reset_sp got=%0d exp=0", sp); end
    checks++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin failures++;
      $display("FAIL reset_empty_full got=%b%b exp=10", stack_empty, stack_full); end
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin failures++;
      $display("FAIL reset_flags got=%b%b exp=00", ovf, unf); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_inc();
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 0, 0, 0, 8'h00, 0);
      checks++; if (adout !== 8'(k) || sp !== 3'd0 || stack_empty !== 1'b1) begin failures++;
        $display("FAIL inc_%0d adout=%h sp=%0d empty=%b exp=%h 0 1", k, adout, sp, stack_empty, 8'(k)); end
    end
  endtask

  task automatic test_jmp_wrap();
    cyc(0, 1, 0, 0, 8'hFE, 0);
    checks++; if (adout !== 8'hFF) begin failures++; $display("FAIL jmp_fe got=%h exp=ff", adout); end
    cyc(1, 0, 0, 0, 8'h00, 0);
    checks++; if (adout !== 8'h00) begin failures++; $display("FAIL inc_wrap got=%h exp=00", adout); end
    cyc(0, 1, 0, 0, 8'hFF, 0);
    checks++; if (adout !== 8'h00) begin failures++; $display("FAIL jmp_ff got=%h exp=00", adout); end
  endtask

  task automatic test_nested_calls();
    cyc(0, 1, 0, 0, 8'h0F, 0);
    checks++; if (adout !== 8'h10) begin failures++; $display("FAIL nest_start got=%h exp=10", adout); end
    cyc(0, 0, 1, 0, 8'h40, 0);
    checks++; if (adout !== 8'h41 || sp !== 3'd1) begin failures++;
      $display("FAIL call1 adout=%h sp=%0d exp=41 1", adout, sp); end
    cyc(0, 0, 1, 0, 8'h80, 0);
    checks++; if (adout !== 8'h81 || sp !== 3'd2) begin failures++;
      $display("FAIL call2 adout=%h sp=%0d exp=81 2", adout, sp); end
    cyc(0, 0, 0, 1, 8'h00, 0);
    checks++; if (adout !== 8'h43 || sp !== 3'd1) begin failures++;
      $display("FAIL ret1 adout=%h sp=%0d exp=43 1", adout, sp); end
    cyc(0, 0, 0, 1, 8'h00, 0);
    checks++; if (adout !== 8'h12 || sp !== 3'd0 || stack_empty !== 1'b1) begin failures++;
      $display("FAIL ret2 adout=%h sp=%0d empty=%b exp=12 0 1", adout, sp, stack_empty); end
  endtask

  task automatic test_overflow();
    bit [7:0] tgt[4]     = '{8'h30, 8'h50, 8'h70, 8'h90};
    bit [7:0] exp_ret[4] = '{8'h73, 8'h53, 8'h33, 8'h14};
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0, tgt[k], 0);
    checks++; if (sp !== 3'd4 || stack_full !== 1'b1 || ovf !== 1'b0) begin failures++;
      $display("FAIL fill sp=%0d full=%b ovf=%b exp=4 1 0", sp, stack_full, ovf); end
    cyc(0, 0, 1, 0, 8'h20, 0);
    checks++; if (adout !== 8'h91 || sp !== 3'd4 || stack_full !== 1'b1 || ovf !== 1'b1) begin failures++;
      $display("FAIL ovf_call adout=%h sp=%0d full=%b ovf=%b exp=91 4 1 1", adout, sp, stack_full, ovf); end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 1, 8'h00, 0);
      checks++; if (adout !== exp_ret[k] || sp !== 3'(3 - k)) begin failures++;
        $display("FAIL ovf_ret%0d adout=%h sp=%0d exp=%h %0d", k, adout, sp, exp_ret[k], 3 - k); end
    end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    cyc(0, 0, 0, 0, 8'h00, 1);
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
  endtask

  task automatic test_underflow_clear();
    cyc(0, 0, 0, 1, 8'h00, 0);
    checks++; if (adout !== 8'h14 || sp !== 3'd0 || unf !== 1'b1) begin failures++;
      $display("FAIL unf_ret adout=%h sp=%0d unf=%b exp=14 0 1", adout, sp, unf); end
    cyc(0, 0, 0, 1, 8'h00, 1);
    checks++; if (unf !== 1'b1) begin failures++; $display("FAIL unf_set_wins got=%b exp=1", unf); end
    cyc(0, 0, 0, 0, 8'h00, 1);
    checks++; if (unf !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b exp=0", unf); end
  endtask

  task automatic test_priority();
    cyc(1, 1, 1, 0, 8'h77, 0);
    checks++; if (adout !== 8'h15 || sp !== 3'd0) begin failures++;
      $display("FAIL priority adout=%h sp=%0d exp=15 0", adout, sp); end
    cyc(0, 1, 1, 1, 8'h60, 0);
    checks++; if (adout !== 8'h61 || sp !== 3'd0) begin failures++;
      $display("FAIL priority_jmp adout=%h sp=%0d exp=61 0", adout, sp); end
  endtask

  task automatic test_async_reset();
    cyc(0, 0, 1, 0, 8'hA0, 0);
    cyc(0, 0, 1, 0, 8'hB0, 0);
    cyc(0, 0, 1, 0, 8'hC0, 0);
    checks++; if (sp !== 3'd3) begin failures++; $display("FAIL pre_reset_sp got=%0d exp=3", sp); end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++; if (adout !== 8'h00 || sp !== 3'd0 || stack_empty !== 1'b1) begin failures++;
      $display("FAIL async_reset adout=%h sp=%0d empty=%b exp=00 0 1", adout, sp, stack_empty); end
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 0, 1, 8'h00, 0);
    checks++; if (adout !== 8'h00 || sp !== 3'd0 || unf !== 1'b1) begin failures++;
      $display("FAIL post_reset_ret adout=%h sp=%0d unf=%b exp=00 0 1", adout, sp, unf); end
  endtask

  task automatic test_random();
    bit i, j, c, r, clr;
    bit [7:0] a;
    for (int n = 0; n < 400; n++) begin
      i   = ($urandom_range(0, 9) < 2);
      j   = ($urandom_range(0, 9) < 2);
      c   = ($urandom_range(0, 9) < 4);
      r   = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 9) < 1);
      a   = 8'($urandom);
      cyc(i, j, c, r, a, clr);
      checks++; if (adout !== m_adout) begin failures++;
        $display("FAIL rnd%0d adout got=%h exp=%h", n, adout, m_adout); end
      checks++; if (sp !== 3'(m_stk.size())) begin failures++;
        $display("FAIL rnd%0d sp got=%0d exp=%0d", n, sp, m_stk.size()); end
      checks++; if (stack_empty !== (m_stk.size() == 0) || stack_full !== (m_stk.size() == 4)) begin failures++;
        $display("FAIL rnd%0d empty_full got=%b%b exp=%b%b", n, stack_empty, stack_full,
                 m_stk.size() == 0, m_stk.size() == 4); end
      checks++; if (ovf !== m_ovf || unf !== m_unf) begin failures++;
        $display("FAIL rnd%0d flags got=%b%b exp=%b%b", n, ovf, unf, m_ovf, m_unf); end
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_jmp_wrap();
    test_nested_calls();
    test_overflow();
    test_underflow_clear();
    test_priority();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/programcounter_stack.md
# programcounter_stack

Parametrised program counter for the fetch stage: drives the instruction-memory address and replaces the single return register with a `DEPTH`-entry hardware return stack, so calls can nest. Command encoding, priority and target offsets match the existing fetch pipeline. Stack overflow and underflow are detected, and the offending command is suppressed. Sits between the instruction decoder (command strobes, `addr_in`) and block memory (`adout`).

## Interface
- `AW`, 8, address width in bits; all address arithmetic is modulo 2^AW.
- `DEPTH`, 4, return-stack entries; must be ≥2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low (asserted when 0).
- `inc`  input  1  increment command.
- `jmp`  input  1  jump command (jump or conditional jump already resolved).
- `call`  input  1  call command.
- `ret`  input  1  return command.
- `addr_in`  input  AW  target address for `jmp` and `call`.
- `err_clr`  input  1  clears the sticky error flags.
- `adout`  output  AW  registered address to block memory.
- `sp`  output  $clog2(DEPTH+1)  current stack occupancy, 0..DEPTH.
- `stack_empty`  output  1  `sp == 0`, combinational from the registered `sp`.
- `stack_full`  output  1  `sp == DEPTH`, combinational from the registered `sp`.
- `ovf`  output  1  sticky: a `call` was attempted while full.
- `unf`  output  1  sticky: a `ret` was attempted while empty.

## Operation
- State: `adout` register, `sp` register, `DEPTH` × AW stack array, `ovf` and `unf` flags.
- Command priority, one action per cycle: `inc` > `jmp` > `call` > `ret` > hold. Lower-priority strobes asserted in the same cycle are ignored.
- `inc`:
  - `adout <= adout + 1`
  - 2^AW−1 wraps to 0
  - stack untouched
- `jmp`: `adout <= addr_in + 1` (wraps), stack untouched.
- `call`, not full:
  - `stack[sp] <= adout` (current value, before update)
  - `sp <= sp + 1`
  - `adout <= addr_in + 1`
- `call`, full:
  - `adout`, `sp` and the stack all hold
  - `ovf <= 1`
- `ret`, not empty:
  - `adout <= stack[sp-1] + 2` (wraps)
  - `sp <= sp - 1`
  - popped entry need not be cleared
- `ret`, empty:
  - `adout` and `sp` hold
  - `unf <= 1`
- Hold (no strobe): all state holds.
- `err_clr`:
  - `ovf <= 0`, `unf <= 0`
  - If a new overflow or underflow occurs in the same cycle, set wins.
- Stack is LIFO. No wrap of `sp`: it saturates by suppression, never by modulo.

## Timing
- Reset (`rst` = 0), asynchronous, immediate:
  - `adout` = 0, `sp` = 0, `ovf` = 0, `unf` = 0, all stack entries = 0
  - `stack_empty` = 1, `stack_full` = 0
- Reset asserted mid-call-chain discards all stack contents. First command after release sees an empty stack.
- Release is synchronous to the design by integration; the block samples commands from the first rising edge with `rst` = 1.
- Latency: each command takes effect at the next rising edge. `adout` is valid one cycle after the strobe; there is no combinational path from inputs to `adout`.
- `sp`, `stack_full` and `stack_empty` reflect the post-edge state in the same cycle `adout` updates.
- Back-to-back commands are legal every cycle. A `ret` immediately after a `call` returns to (address before the call) + 2.
- The flags update on the edge following the faulting command and stay high until `err_clr` or reset.

## Test plan
- Reset/increment:
  - Stimulus: hold `rst` = 0, release, assert `inc` for 3 cycles.
  - Response: `adout` = 0 then 1, 2, 3; `sp` = 0; `stack_empty` = 1.
- Wrap and jump (AW = 8):
  - Stimulus: `jmp` with `addr_in` = 0xFE, then `inc`.
  - Response: `adout` = 0xFF then 0x00.
  - Stimulus: `jmp` with `addr_in` = 0xFF.
  - Response: `adout` = 0x00.
- Nested calls (DEPTH = 4):
  - From `adout` = 0x10: `call` 0x40; `call` 0x80 (pushed value 0x41).
  - Response: `sp` = 2.
  - Then `ret` → `adout` = 0x43, `sp` = 1; `ret` → `adout` = 0x12, `sp` = 0.
- Overflow:
  - Stimulus: 4 calls to fill the stack, then a 5th call to 0x20.
  - Response: `adout` unchanged, `sp` = 4, `stack_full` = 1, `ovf` = 1.
  - Then 4 returns restore the original chain in LIFO order.
- Underflow and clear:
  - Stimulus: `ret` on an empty stack.
  - Response: `adout` holds, `unf` = 1.
  - Stimulus: `err_clr` together with another `ret` on an empty stack.
  - Response: `unf` stays 1. A lone `err_clr` then clears it.
- Priority and async reset:
  - Stimulus: `inc`, `jmp` and `call` asserted together.
  - Response: increment only; `sp` unchanged.
  - Stimulus: drop `rst` between clock edges with `sp` = 3.
  - Response: `adout` = 0 and `sp` = 0 immediately, without waiting for a clock edge.
